// File: rtl/lbp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lbp_pkg
// Description : Shared constants and types for the LBP scan controller and
//               its code calculator. Holds the default frame geometry, the
//               controller state encoding, the 3x3 neighbour weights and the
//               packing of a 3x3 window into a flat 72-bit vector.
// Revision    : 1.0 - initial release
// ============================================================================
package lbp_pkg;

  // Default frame geometry.
  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;

  // Controller state encoding, width fixed at 2 bits.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Neighbour weights; a bit is set when the neighbour is >= the centre.
  localparam logic [7:0] c_wt_tl = 8'd1;
  localparam logic [7:0] c_wt_t  = 8'd2;
  localparam logic [7:0] c_wt_tr = 8'd4;
  localparam logic [7:0] c_wt_l  = 8'd8;
  localparam logic [7:0] c_wt_r  = 8'd16;
  localparam logic [7:0] c_wt_bl = 8'd32;
  localparam logic [7:0] c_wt_b  = 8'd64;
  localparam logic [7:0] c_wt_br = 8'd128;

  // Flat window: pixel (row r, column c) lives at bits [(r*3+c)*8 +: 8],
  // row 0 is the top row, column 0 the leftmost column.
  localparam int c_win_w = 72;

  function automatic logic [7:0] win_px(input logic [c_win_w-1:0] win,
                                        input int row, input int col);
    return win[(row*3+col)*8 +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lbp_code_calc.sv
`default_nettype none
// ============================================================================
// Module      : lbp_code_calc
// Description : Purely combinational 3x3 local-binary-pattern evaluator.
//               Compares each of the eight neighbours against the centre
//               (unsigned) and sums the weights of those >= centre.
// Ports       : window - 72-bit packed 3x3 window (see lbp_pkg::win_px)
//               code   - 8-bit LBP code
// Revision    : 1.0 - initial release
// ============================================================================
module lbp_code_calc
  import lbp_pkg::*;
(
  input  logic [c_win_w-1:0] window,
  output logic [7:0]         code
);

  logic [7:0] w_centre;

  always_comb begin
    w_centre = win_px(window, 1, 1);
    code     = 8'd0;
    if (win_px(window, 0, 0) >= w_centre) code = code | c_wt_tl;
    if (win_px(window, 0, 1) >= w_centre) code = code | c_wt_t;
    if (win_px(window, 0, 2) >= w_centre) code = code | c_wt_tr;
    if (win_px(window, 1, 0) >= w_centre) code = code | c_wt_l;
    if (win_px(window, 1, 2) >= w_centre) code = code | c_wt_r;
    if (win_px(window, 2, 0) >= w_centre) code = code | c_wt_bl;
    if (win_px(window, 2, 1) >= w_centre) code = code | c_wt_b;
    if (win_px(window, 2, 2) >= w_centre) code = code | c_wt_br;
  end

endmodule
`default_nettype wire

// File: rtl/lbp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lbp_scan_ctrl
// Description : Raster-scan sequencer for the LBP engine. Fetches the grey
//               image three rows at a time (one column per 3 reads), keeps
//               a sliding 3x3 window and emits one LBP result per interior
//               pixel. Raises a sticky finish flag when the frame is done.
// Ports       : clk        - clock, all logic on posedge
//               reset      - asynchronous active-low reset
//               gray_ready - grey memory ready; reads issue only while high
//               gray_req   - read request for the current cycle
//               gray_addr  - read address {row, col}
//               gray_data  - read data, captured at the end of a req cycle
//               lbp_valid  - one-cycle result write strobe
//               lbp_addr   - result address of the centre pixel
//               lbp_data   - LBP code
//               finish     - frame complete, held until reset
// Revision    : 1.0 - initial release
// ============================================================================
module lbp_scan_ctrl #(
  parameter int IMG_W  = lbp_pkg::IMG_W,
  parameter int IMG_H  = lbp_pkg::IMG_H,
  parameter int ADDR_W = lbp_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [7:0]        gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  import lbp_pkg::*;

  localparam int c_col_w = $clog2(IMG_W);
  localparam int c_row_w = ADDR_W - c_col_w;
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMG_W - 1);
  // Top row of the window for the last centre row (IMG_H-2).
  localparam logic [c_row_w-1:0] c_last_top = c_row_w'(IMG_H - 3);

  state_t r_state;
  state_t w_state_nxt;

  // Window position: r_top is the top row of the window (centre row - 1),
  // so all counters clear to zero and the first address is 0.
  logic [c_row_w-1:0] r_top;
  logic [c_col_w-1:0] r_x;
  logic [1:0]         r_phase;
  // Number of fully loaded columns preceding the current one (saturates at 2).
  logic [1:0]         r_ncols;
  // Set once the last read of the frame has been captured.
  logic               r_last;

  // Window columns: r_col0 oldest, r_col2 the one being loaded.
  logic [2:0][7:0]    r_col0;
  logic [2:0][7:0]    r_col1;
  logic [2:0][7:0]    r_col2;

  logic               r_lbp_valid;
  logic [ADDR_W-1:0]  r_lbp_addr;
  logic [7:0]         r_lbp_data;

  logic               w_fire;
  logic [c_row_w-1:0] w_row;
  logic [c_row_w-1:0] w_centre_y;
  logic [c_col_w-1:0] w_centre_x;
  logic [c_win_w-1:0] w_window;
  logic [7:0]         w_code;

  assign w_fire     = (r_state == FETCH) && gray_ready && !r_last;
  assign w_row      = r_top + c_row_w'(r_phase);
  assign w_centre_y = r_top + 1'b1;
  assign w_centre_x = r_x - 1'b1;

  // The window seen by the code calculator on a phase-2 capture: the bottom
  // pixel of the newest column comes straight from the memory bus so the
  // result can be registered on the same edge that captures it.
  always_comb begin
    w_window = '0;
    for (int r = 0; r < 3; r++) begin
      w_window[(r*3+0)*8 +: 8] = r_col0[r];
      w_window[(r*3+1)*8 +: 8] = r_col1[r];
      w_window[(r*3+2)*8 +: 8] = (r == 2) ? gray_data : r_col2[r];
    end
  end

  lbp_code_calc u_code_calc (
    .window (w_window),
    .code   (w_code)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (gray_ready) w_state_nxt = FETCH;
      FETCH:   if (r_last)     w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    gray_req  = w_fire;
    gray_addr = {w_row, r_x};
    finish    = (r_state == DONE);
    lbp_valid = r_lbp_valid;
    lbp_addr  = r_lbp_addr;
    lbp_data  = r_lbp_data;
  end

  // ----------------------------------------------------- scan counters/window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_top       <= '0;
      r_x         <= '0;
      r_phase     <= 2'd0;
      r_ncols     <= 2'd0;
      r_last      <= 1'b0;
      r_col0      <= '0;
      r_col1      <= '0;
      r_col2      <= '0;
      r_lbp_valid <= 1'b0;
      r_lbp_addr  <= '0;
      r_lbp_data  <= 8'd0;
    end else begin
      r_lbp_valid <= 1'b0;
      if (w_fire) begin
        // Shift happens as the first read of a new column lands; stale data
        // carried across a row wrap is harmless because r_ncols is zero.
        if (r_phase == 2'd0) begin
          r_col0 <= r_col1;
          r_col1 <= r_col2;
        end
        r_col2[r_phase] <= gray_data;

        if (r_phase == 2'd2) begin
          r_phase <= 2'd0;
          if (r_ncols == 2'd2) begin
            r_lbp_valid <= 1'b1;
            r_lbp_addr  <= {w_centre_y, w_centre_x};
            r_lbp_data  <= w_code;
          end
          if (r_x == c_last_col) begin
            r_x     <= '0;
            r_ncols <= 2'd0;
            if (r_top == c_last_top) begin
              r_last <= 1'b1;
            end else begin
              r_top <= r_top + 1'b1;
            end
          end else begin
            r_x <= r_x + 1'b1;
            if (r_ncols != 2'd2) begin
              r_ncols <= r_ncols + 2'd1;
            end
          end
        end else begin
          r_phase <= r_phase + 2'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lbp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lbp_scan_ctrl
// Description : Scoreboard bench for lbp_scan_ctrl at 128x128. The expected
//               result stream of a frame is queued up front; a monitor pops
//               and compares on every lbp_valid. Covers reset values, the
//               initial fetch order, first-result latency, a stall that
//               overlaps a result write, a mid-frame reset and the finish
//               timing of a full frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lbp_scan_ctrl;

  localparam int W  = 128;
  localparam int H  = 128;
  localparam int AW = 14;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mode   = 1;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lbp_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  // Image 1: gray = x. Image 2: bands of 0x55 / x / y / scrambled rows.
  function automatic logic [7:0] img(input int m, input int x, input int y);
    if (m == 1) return 8'(x);
    if (y < 32) return 8'h55;
    if (y < 64) return 8'(x);
    if (y < 96) return 8'(y);
    return 8'((x * 29) ^ (y * 53) ^ (x * y));
  endfunction

  function automatic logic [7:0] model_code(input int m, input int x, input int y);
    logic [7:0] c;
    logic [7:0] r;
    c = img(m, x, y);
    r = 8'd0;
    r[0] = img(m, x-1, y-1) >= c;
    r[1] = img(m, x,   y-1) >= c;
    r[2] = img(m, x+1, y-1) >= c;
    r[3] = img(m, x-1, y  ) >= c;
    r[4] = img(m, x+1, y  ) >= c;
    r[5] = img(m, x-1, y+1) >= c;
    r[6] = img(m, x,   y+1) >= c;
    r[7] = img(m, x+1, y+1) >= c;
    return r;
  endfunction

  // Hand-derived codes inside uniform bands, model elsewhere.
  function automatic logic [7:0] exp_code(input int m, input int x, input int y);
    if (m == 1)              return 8'hD6;
    if (y >= 1  && y <= 30)  return 8'hFF;
    if (y >= 33 && y <= 62)  return 8'hD6;
    if (y >= 65 && y <= 94)  return 8'hF8;
    return model_code(m, x, y);
  endfunction

  always_comb gray_data = img(mode, int'(gray_addr[6:0]), int'(gray_addr[13:7]));

  task automatic push_frame(input int m);
    for (int y = 1; y <= H-2; y++)
      for (int x = 1; x <= W-2; x++)
        sb.push_back('{a: AW'(y*W + x), d: exp_code(m, x, y)});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask

  // ------------------------------------------------------- result monitor
  int            n_writes = 0;
  int            last_write_cyc = -1;
  int            first_valid_cyc = -1;
  logic [AW-1:0] last_write_addr = '0;
  always @(negedge clk) begin
    if (reset && lbp_valid) begin
      exp_t e;
      n_writes++;
      last_write_cyc  = cyc;
      last_write_addr = lbp_addr;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL lbp_write: got addr=%0d data=0x%02h, want no write", lbp_addr, lbp_data);
      end else begin
        e = sb.pop_front();
        if (lbp_addr !== e.a || lbp_data !== e.d) begin
          errors++;
          $display("FAIL lbp_write: got addr=%0d data=0x%02h, want addr=%0d data=0x%02h",
                   lbp_addr, lbp_data, e.a, e.d);
        end
      end
    end
  end

  // -------------------------------------------- initial fetch order monitor
  int            n_req = 0;
  int            req9_cyc = -1;
  logic [AW-1:0] seq_exp [9] = '{14'd0, 14'd128, 14'd256, 14'd1, 14'd129,
                                 14'd257, 14'd2, 14'd130, 14'd258};
  always @(negedge clk) begin
    if (reset && gray_req) begin
      if (n_req < 9) begin
        checks++;
        if (gray_addr !== seq_exp[n_req]) begin
          errors++;
          $display("FAIL fetch_order[%0d]: got addr=%0d, want %0d", n_req, gray_addr, seq_exp[n_req]);
        end
        if (n_req == 8) req9_cyc = cyc;
      end
      n_req++;
    end
  end

  // ---------------------------------------------------- finish edge count
  int   finish_rises = 0;
  logic finish_q = 1'b0;
  always @(negedge clk) begin
    if (finish && !finish_q) finish_rises++;
    finish_q = finish;
  end

  // -------------------------------------------------------------- watchdog
  initial begin
    #1200000;
    $display("FAIL watchdog: got timeout, want bench completion");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    int to;
    int wb;
    reset      = 1'b0;
    gray_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gray_req",  32'(gray_req),  0);
    chk("rst_gray_addr", 32'(gray_addr), 0);
    chk("rst_lbp_valid", 32'(lbp_valid), 0);
    chk("rst_lbp_addr",  32'(lbp_addr),  0);
    chk("rst_lbp_data",  32'(lbp_data),  0);
    chk("rst_finish",    32'(finish),    0);

    // Frame 1: gray = x, aborted by reset part way through.
    mode = 1;
    push_frame(1);
    @(posedge clk);
    #1 reset = 1'b1; gray_ready = 1'b1;
    repeat (20000) @(posedge clk);
    @(negedge clk);
    chk("frame1_no_finish", 32'(finish), 0);
    chk("first_valid_latency", 32'(first_valid_cyc - req9_cyc), 1);
    reset = 1'b0;
    #1;
    chk("midrst_gray_req",  32'(gray_req),  0);
    chk("midrst_gray_addr", 32'(gray_addr), 0);
    chk("midrst_lbp_valid", 32'(lbp_valid), 0);
    chk("midrst_lbp_addr",  32'(lbp_addr),  0);
    chk("midrst_lbp_data",  32'(lbp_data),  0);
    chk("midrst_finish",    32'(finish),    0);
    repeat (3) @(negedge clk);

    // Frame 2: banded image, full run with a stall overlapping a write.
    mode = 2;
    sb.delete();
    push_frame(2);
    wb = n_writes;
    @(posedge clk);
    #1 reset = 1'b1;
    to = 0;
    while (!(gray_req && gray_addr == AW'(266)) && to < 2000) begin
      @(negedge clk);
      to++;
    end
    chk("stall_trigger_seen", 32'(to < 2000), 1);
    @(posedge clk);
    #1 gray_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("stall_lbp_valid", 32'(lbp_valid), 1);
        chk("stall_lbp_addr",  32'(lbp_addr),  137);
      end
      chk("stall_gray_req",  32'(gray_req),  0);
      chk("stall_gray_addr", 32'(gray_addr), 11);
    end
    @(posedge clk);
    #1 gray_ready = 1'b1;

    to = 0;
    while (!finish && to < 60000) begin
      @(negedge clk);
      to++;
    end
    chk("finish_before_timeout", 32'(finish), 1);
    chk("finish_latency",  32'(cyc - last_write_cyc), 1);
    chk("frame2_writes",   32'(n_writes - wb), 15876);
    chk("last_write_addr", 32'(last_write_addr), 16254);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    repeat (5) @(negedge clk);
    chk("finish_sticky",   32'(finish),   1);
    chk("done_no_req",     32'(gray_req), 0);
    chk("finish_rises",    32'(finish_rises), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
